// File: rtl/msg_stream_arbiter_pkg.sv
// msg_pkg: arbiter state encoding and default datapath widths for the message stream.
package msg_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;
    function automatic int data_w(input int bytes);
        return 8 * bytes;
    endfunction
    localparam int DEF_DATA_BYTES = 8;
    localparam int DEF_DATA_W = data_w(DEF_DATA_BYTES);
    localparam int DEF_KEEP_W = DEF_DATA_BYTES;
endpackage

// File: rtl/msg_stream_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first requester at or after ptr.
module rr_pick
    import msg_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);
    logic [SW:0] k;
    // Walk offsets from far to near so the nearest requester overwrites last.
    always_comb begin
        gnt_idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = {1'b0, ptr} + (SW + 1)'(i);
            k = k >= (SW + 1)'(N) ? k - (SW + 1)'(N) : k;
            if (req[k[SW-1:0]]) gnt_idx = k[SW-1:0];
        end
    end
    assign gnt_any = |req;
endmodule

// File: rtl/msg_stream_arbiter.sv
// msg_stream_arbiter: packet-locked round-robin AXI-Stream arbiter for the message datapath.
// Optional runaway-packet guard enabled by defining MSG_ARB_BEAT_LIMIT_EN.
module msg_stream_arbiter
    import msg_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_BYTES = DEF_DATA_BYTES,
    parameter int TKEEP_WIDTH = DEF_KEEP_W,
    parameter int MAX_BEATS = 4,
    localparam int SW = $clog2(NUM_SRC),
    localparam int DW = data_w(DATA_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC*DW-1:0]         s_tdata,
    input  logic [NUM_SRC*TKEEP_WIDTH-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC-1:0]            s_tuser,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DW-1:0]                 m_tdata,
    output logic [TKEEP_WIDTH-1:0]        m_tkeep,
    output logic                          m_tlast,
    output logic                          m_tuser,
    output logic [SW-1:0]                 m_tid,
    output logic                          arb_busy,
    output logic                          trunc_pulse
);
    arb_state_t    state;
    logic [SW-1:0] grant, rr_ptr, pick_idx, next_ptr;
    logic          pick_any, busy_q, in_busy, sel_valid, sel_last, sel_user, xfer;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req(s_tvalid),
        .ptr(rr_ptr),
        .gnt_idx(pick_idx),
        .gnt_any(pick_any)
    );

    assign in_busy   = state == BUSY;
    assign sel_valid = s_tvalid[grant];
    assign sel_last  = s_tlast[grant];
    assign sel_user  = s_tuser[grant];
    assign m_tdata   = s_tdata[grant*DW +: DW];
    assign m_tkeep   = s_tkeep[grant*TKEEP_WIDTH +: TKEEP_WIDTH];
    assign m_tvalid  = in_busy & sel_valid;
    assign xfer      = m_tvalid & m_tready;
    assign m_tid     = grant;
    assign arb_busy  = busy_q;
    assign next_ptr  = grant == SW'(NUM_SRC - 1) ? '0 : grant + 1'b1;

    always_comb begin
        s_tready = '0;
        s_tready[grant] = in_busy ? m_tready : state == DRAIN;
    end

`ifdef MSG_ARB_BEAT_LIMIT_EN
    localparam int BW = $clog2(MAX_BEATS + 1);
    logic [BW-1:0] beat_cnt;
    logic          limit_hit;
    assign limit_hit   = in_busy && beat_cnt == BW'(MAX_BEATS - 1) && !sel_last;
    assign m_tlast     = in_busy & (sel_last | limit_hit);
    assign m_tuser     = in_busy & (sel_user | limit_hit);
    assign trunc_pulse = xfer & limit_hit;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) beat_cnt <= '0;
        else beat_cnt <= state == IDLE ? '0 :
                         (xfer && beat_cnt != BW'(MAX_BEATS)) ? beat_cnt + 1'b1 : beat_cnt;
    end
`else
    logic unused_max_beats;
    assign unused_max_beats = ^MAX_BEATS;
    assign m_tlast     = in_busy & sel_last;
    assign m_tuser     = in_busy & sel_user;
    assign trunc_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant  <= pick_idx;
                    state  <= BUSY;
                    busy_q <= 1'b1;
                end
                BUSY: if (xfer && sel_last) begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
`ifdef MSG_ARB_BEAT_LIMIT_EN
                else if (xfer && limit_hit) state <= DRAIN;
                // Swallow the rest of a truncated packet so it never reaches the message stage.
                DRAIN: if (sel_valid && sel_last) begin
                    rr_ptr <= next_ptr;
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/msg_stream_arbiter.md
# msg_stream_arbiter

Round-robin, packet-locked arbiter that shares the single AXI-Stream input of the message datapath between `NUM_SRC` upstream requesters. Once granted, a source holds the output until it sends `tlast`. The selected source index is forwarded so the message stage can tag results. An optional beat-limit guard terminates runaway packets with `tuser`, which the message stage reports as `msg_error`.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters (≥2)
- `DATA_BYTES`, 8: bytes per beat
- `TKEEP_WIDTH`, 8: keep width, equal to `DATA_BYTES`
- `MAX_BEATS`, 4: beat limit per packet (`MAX_MSG_BYTES/DATA_BYTES`); used only with the guard

Ports (`SW = $clog2(NUM_SRC)`):
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `s_tvalid` in `NUM_SRC`: per-source valid
- `s_tready` out `NUM_SRC`: per-source ready
- `s_tdata` in `NUM_SRC*8*DATA_BYTES`: packed; source i at slice `[i*8*DATA_BYTES +: 8*DATA_BYTES]`
- `s_tkeep` in `NUM_SRC*TKEEP_WIDTH`: packed, same layout
- `s_tlast` in `NUM_SRC`: per-source last
- `s_tuser` in `NUM_SRC`: per-source error flag
- `m_tvalid`, `m_tready` out/in 1: downstream handshake
- `m_tdata`, `m_tkeep` out: selected beat
- `m_tlast`, `m_tuser` out 1: selected flags, possibly forced by the guard
- `m_tid` out `SW`: granted source index
- `arb_busy` out 1: a grant is held
- `trunc_pulse` out 1: one-cycle pulse when the guard truncates a packet

## Operation
States:
- `IDLE`
  - If any `s_tvalid` is set, register `grant` = first requester at or after `rr_ptr` (wrapping modulo `NUM_SRC`), then go to `BUSY`.
  - All `s_tready` = 0 and `m_tvalid` = 0.
- `BUSY`
  - `m_*` = combinational mux of `s_*[grant]`.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` = 0.
  - On a beat transfer (`m_tvalid && m_tready`) with `m_tlast`: `rr_ptr` ← `grant+1` (wraps), go to `IDLE`.
  - If the granted source drops `tvalid` mid-packet, the grant is held with no timeout.
- `DRAIN` (guard only)
  - `s_tready[grant]` = 1 and `m_tvalid` = 0; discard beats until `s_tlast[grant]` transfers.
  - Then `rr_ptr` ← `grant+1`, go to `IDLE`.

Beat counter:
- `beat_cnt` has `$clog2(MAX_BEATS+1)` bits, cleared in `IDLE`.
- Increments on each transfer in `BUSY` and saturates at `MAX_BEATS`.

Simultaneous requests: round-robin order from `rr_ptr`; no requester waits more than `NUM_SRC-1` packets.

A single-beat packet (`tlast` on the first beat) is legal: `BUSY` lasts one transfer.

`m_tdata` and `m_tkeep` pass through unmodified; zeroing of `tkeep`-masked bytes belongs downstream.

## Timing
- Reset values: state `IDLE`, `grant` 0, `rr_ptr` 0, `beat_cnt` 0, `s_tready` 0, `m_tvalid` 0, `m_tlast` 0, `m_tuser` 0, `m_tid` 0, `arb_busy` 0, `trunc_pulse` 0.
- Arbitration latency: one cycle. A request seen in `IDLE` at cycle N gives the first possible transfer at cycle N+1.
- Back-to-back packets have exactly one idle bubble between them, in the `IDLE` cycle.
- `m_tid` and `arb_busy` are registered and valid throughout `BUSY`.
- All data paths are combinational with zero latency.
- `s_tready` depends combinationally on `m_tready`.
- Reset asserted mid-packet: the packet is abandoned immediately and all outputs take their reset values. The source must restart its packet.

## Configuration
Macro `MSG_ARB_BEAT_LIMIT_EN`.

Defined:
- In `BUSY`, a transfer with `beat_cnt == MAX_BEATS-1` and `s_tlast == 0` forces `m_tlast` = 1 and `m_tuser` = 1 on that beat.
- The same transfer pulses `trunc_pulse` and moves to `DRAIN`.
- A natural `tlast` on the limit beat passes unmodified and does not truncate.

Undefined:
- No `DRAIN` state and no beat counter.
- `m_tlast`/`m_tuser` are pure pass-through; `trunc_pulse` is tied to 0.

## Structure
- Shared package `msg_pkg`: `arb_state_t` enum (`IDLE`, `BUSY`, `DRAIN`) and width constants derived from `DATA_BYTES`/`TKEEP_WIDTH`.
- Sub-module `rr_pick`: combinational rotating-priority picker (inputs `req[NUM_SRC]`, `ptr`; outputs `gnt_idx`, `gnt_any`). It is reusable by other schedulers in the design.

## Test plan
- **Single source:** source 2 sends a 3-beat packet, `tlast` on beat 3, `m_tready`=1 → `m_tid`=2, data on cycles 1–3 after the request, `IDLE` on cycle 4, `rr_ptr`=3.
- **Fair rotation:** all 4 sources continuously send 1-beat packets from reset → grant order 0,1,2,3,0, one bubble between each packet.
- **Backpressure:** `m_tready` low for 5 cycles mid-packet while source 1 is granted → `s_tready[1]`=0 and the data stays stable; a competing source 0 request is not granted until source 1's `tlast`.
- **Source stall:** the granted source drops `tvalid` for 3 cycles mid-packet → grant held, `m_tvalid`=0, other sources get no `s_tready`.
- **Guard (macro on):** a 6-beat packet with `MAX_BEATS`=4 → beat 4 carries `m_tlast`=1, `m_tuser`=1 and `trunc_pulse` for one cycle; beats 5–6 are accepted and dropped; the next source is then granted.
- **Reset mid-packet:** `rst` low during beat 2 → all outputs return to reset values asynchronously; after release the first request is arbitrated from `rr_ptr`=0.
